cla_sub_seq: RTL
================

// Module: cla_sub_seq
// PURPOSE
//  Multi-cycle 64-bit subtractor, the inverse of the CLA adder datapath.
//  Computes D = A - B - Bi one CHUNK_WIDTH slice per cycle, with the borrow
//  chained between slices. Produces unsigned borrow-out, signed overflow and
//  zero flags. Uses valid/ready handshakes on both sides, so the ALU issue
//  stage can stall it.
// PARAMETERS
//  DATA_WIDTH   64   operand/result width; must be an integer multiple of CHUNK_WIDTH
//  CHUNK_WIDTH  16   bits subtracted per cycle; N = DATA_WIDTH/CHUNK_WIDTH
// PORTS
//  sys_clk    in   1           single clock, rising edge
//  sys_rst    in   1           synchronous, active-high reset
//  in_valid   in   1           operands A/B/Bi are valid
//  in_ready   out  1           block can accept operands (IDLE)
//  A          in   DATA_WIDTH  minuend
//  B          in   DATA_WIDTH  subtrahend
//  Bi         in   1           borrow-in
//  out_valid  out  1           result valid (DONE)
//  out_ready  in   1           consumer takes the result
//  D          out  DATA_WIDTH  difference, mod 2^DATA_WIDTH
//  Bo         out  1           borrow-out: 1 iff A < B + Bi (unsigned)
//  Ovf        out  1           signed overflow: A[msb]!=B[msb] && D[msb]!=A[msb]
//  Zero       out  1           D == 0
// BEHAVIOUR
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  - Reset (sync, any state): state=IDLE, chunk counter=0, D=0, Bo=0, Ovf=0,
//    Zero=0, out_valid=0, in_ready=1 on the cycle after the reset edge.
//  - Accept: on an edge where state==IDLE && in_valid, register A, B and ~Bi
//    (the carry-in), clear the counter and go to BUSY. Later changes on A/B/Bi are ignored.
//  - BUSY: each edge computes slice k: {c,D[k]} = A[k] + ~B[k] + c. Increment k.
//    After slice N-1, the final c gives Bo=~c, and Ovf/Zero are computed from the
//    full D. Then go to DONE.
//  - Latency: when accepted at edge T, out_valid is high after edge T+N
//    (N=4 by default). With N=1, the result is ready after edge T+1.
//  - DONE: D/Bo/Ovf/Zero are held stable while out_ready=0. On an edge with
//    out_ready=1, go to IDLE. There is no same-cycle re-accept, so throughput is
//    one op per N+2 cycles.
//  - in_valid while not IDLE: ignored, and no operands are latched.
//  - D/flags are updated only in BUSY. They keep their last value in IDLE and are
//    meaningful only while out_valid=1.
//  - Reset mid-BUSY or mid-DONE: the operation is abandoned and no result is emitted.
//  - All arithmetic is unsigned modular. The slice carry stays internal (1 bit);
//    there is no width growth.
// TESTING
//  1 A=10,B=3,Bi=0 accepted at edge T -> out_valid after T+4; D=7,Bo=0,Ovf=0,Zero=0.
//  2 A=0,B=1,Bi=0 -> D=64'hFFFF_FFFF_FFFF_FFFF, Bo=1, Ovf=0, Zero=0.
//  3 A=64'h8000_0000_0000_0000,B=1 -> D=64'h7FFF_FFFF_FFFF_FFFF, Ovf=1, Bo=0.
//  4 A=64'h0000_0000_0001_0000,B=1 -> D=64'h0000_0000_0000_FFFF (borrow crosses a slice);
//    A=5,B=4,Bi=1 -> D=0, Zero=1, Bo=0.
//  5 out_ready=0 for 10 cycles in DONE, in_valid=1 with new operands -> out_valid stays 1,
//    D is stable, in_ready=0, and the new operands are not taken. When out_ready=1:
//    IDLE next cycle, then accept.
//  6 sys_rst=1 for one edge during the 2nd BUSY cycle -> next cycle in_ready=1,
//    out_valid=0, D=0. The next op (A=9,B=9) gives D=0,Zero=1 with correct latency.
//  Plus: 1000 random A/B/Bi vs model {Bo,D}=A-B-Bi with random out_ready stalls.

Source files
------------

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: D = A - B - Bi, one CHUNK_WIDTH slice per cycle, borrow chained between slices.
// Latency: result valid N = DATA_WIDTH/CHUNK_WIDTH edges after the accept edge; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready is seen.
module cla_sub_seq #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16   // DATA_WIDTH must be an integer multiple of this
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Bi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  Bo,
    output logic                  Ovf,
    output logic                  Zero
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic                   carry_q;     // carry into the current slice; 0 means borrow pending
    logic [CNT_W-1:0]       cnt;         // index of the slice computed on the next BUSY edge

    logic [CHUNK_WIDTH-1:0] a_slice;
    logic [CHUNK_WIDTH-1:0] b_slice;
    logic [CHUNK_WIDTH-1:0] diff_slice;
    logic                   carry_nxt;
    logic [DATA_WIDTH-1:0]  d_nxt;
    logic                   last_slice;

    // Select the active slice, add A + ~B + carry, and merge the slice into the running difference.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_slice = a_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_slice = b_q[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        {carry_nxt, diff_slice} = {1'b0, a_slice} + {1'b0, ~b_slice}
                                + {{CHUNK_WIDTH{1'b0}}, carry_q};
        d_nxt = D;
        for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k)) begin
                d_nxt[k*CHUNK_WIDTH +: CHUNK_WIDTH] = diff_slice;
            end
        end
        last_slice = (cnt == CNT_W'(N - 1));
    end

    // Control FSM with registered handshakes; the datapath state only moves while BUSY.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            D         <= '0;
            Bo        <= 1'b0;
            Ovf       <= 1'b0;
            Zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        carry_q  <= ~Bi;          // A - B - Bi == A + ~B + ~Bi
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    D       <= d_nxt;
                    carry_q <= carry_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_slice) begin
                        Bo        <= ~carry_nxt;  // no final carry means the result wrapped
                        Ovf       <= (a_q[MSB] != b_q[MSB]) && (d_nxt[MSB] != a_q[MSB]);
                        Zero      <= (d_nxt == '0);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
